seg_frame_builder: RTL

SEG_FRAME_BUILDER -- requirements
Module: seg_frame_builder

---
 rtl/seg_pkg.sv | 22 ++
 rtl/hex7seg.sv | 20 ++
 rtl/seg_frame_builder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment frame builder.
package seg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENC,
      ARM,
      PULSE,
      WAIT_LO,
      WAIT_HI
   } state_t;

   // Active-high byte with every segment and the decimal point dark.
   localparam logic [7:0] SEG_OFF = 8'h00;

   // Active-high g..a patterns for hex digits 0..F.
   localparam logic [0:15][6:0] HEX_SEG = {
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to segment byte encoder with blank and polarity control.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   input  logic       dp_i,
   input  logic       blank_i,
   input  logic       active_low_i,
   output logic [7:0] seg_o
);

   logic [7:0] raw;

   // Blank darkens the whole byte including dp; polarity is applied last.
   always_comb begin
      raw   = blank_i ? SEG_OFF : {dp_i, HEX_SEG[hex_i]};
      seg_o = active_low_i ? ~raw : raw;
   end

endmodule

// File: rtl/seg_frame_builder.sv
// Builds a 64-bit seven-segment frame digit by digit and hands it to a
// serializer with a start pulse and an ser_en handshake guarded by a timeout.
module seg_frame_builder
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = 100000,
   parameter int unsigned START_WIDTH    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter bit          ACTIVE_LOW     = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        upd,
   input  logic [31:0] hex_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  blank_in,
   input  logic        ser_en,
   output logic [63:0] pdata,
   output logic        start,
   output logic        busy,
   output logic        err
);

   localparam int unsigned RW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int unsigned CMAX = (START_WIDTH > TIMEOUT_CYCLES) ? START_WIDTH : TIMEOUT_CYCLES;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam logic [7:0]  BYTE_OFF = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

   state_t         state_q, state_d;
   logic [RW-1:0]  ref_q;
   logic           tick;
   logic           pend_q, pend_d;
   logic [31:0]    hex_sh_q, hex_wk_q;
   logic [7:0]     dp_sh_q, dp_wk_q;
   logic [7:0]     blank_sh_q, blank_wk_q;
   logic [2:0]     idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;
   logic [63:0]    pdata_q;
   logic           load_wk;
   logic           wr_byte;
   logic [7:0]     enc_byte;

   assign tick = (ref_q == RW'(REFRESH_CYCLES - 1));

   // Free-running refresh counter, wrapping at REFRESH_CYCLES-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       ref_q <= '0;
      else if (tick) ref_q <= '0;
      else           ref_q <= ref_q + 1'b1;
   end

   // Shadow copy of the display inputs, refreshed on every upd regardless of state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hex_sh_q   <= '0;
         dp_sh_q    <= '0;
         blank_sh_q <= '0;
      end else if (upd) begin
         hex_sh_q   <= hex_in;
         dp_sh_q    <= dp_in;
         blank_sh_q <= blank_in;
      end
   end

   // A new request wins over the clear so an upd arriving on the ENC entry
   // edge still yields a follow-up frame with the fresh shadow contents.
   always_comb begin
      pend_d = pend_q;
      if (upd || tick) pend_d = 1'b1;
      else if (load_wk) pend_d = 1'b0;
   end

   // Working copy frozen for the duration of one frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hex_wk_q   <= '0;
         dp_wk_q    <= '0;
         blank_wk_q <= '0;
      end else if (load_wk) begin
         hex_wk_q   <= hex_sh_q;
         dp_wk_q    <= dp_sh_q;
         blank_wk_q <= blank_sh_q;
      end
   end

   hex7seg u_hex7seg (
      .hex_i        (hex_wk_q[{idx_q, 2'b00} +: 4]),
      .dp_i         (dp_wk_q[idx_q]),
      .blank_i      (blank_wk_q[idx_q]),
      .active_low_i (ACTIVE_LOW),
      .seg_o        (enc_byte)
   );

   // Next-state logic: encode, arm, pulse start, then follow the ser_en handshake.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      load_wk = 1'b0;
      wr_byte = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q) begin
               state_d = ENC;
               idx_d   = '0;
               load_wk = 1'b1;
            end
         end
         ENC: begin
            wr_byte = 1'b1;
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = ARM;
         end
         ARM: begin
            state_d = PULSE;
            cnt_d   = '0;
         end
         PULSE: begin
            if (cnt_q == CW'(START_WIDTH - 1)) begin
               state_d = WAIT_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_LO: begin
            if (!ser_en) begin
               state_d = WAIT_HI;
               cnt_d   = '0;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_HI: begin
            if (ser_en) begin
               state_d = IDLE;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, counters, sticky error and pending flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
      end
   end

   // Frame register: only ENC writes it, one byte per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          pdata_q <= {8{BYTE_OFF}};
      else if (wr_byte) pdata_q[{idx_q, 3'b000} +: 8] <= enc_byte;
   end

   assign pdata = pdata_q;
   assign start = (state_q == PULSE);
   assign busy  = (state_q != IDLE);
   assign err   = err_q;

endmodule
